// File: rtl/tss_sad_cmp.sv
// SAD accumulate and minimum-select stage for the three-step motion estimator.
// Optional build macro: MV_ZERO_BIAS_EN (credits ZBIAS to the zero-offset candidate).
module tss_sad_cmp #(
  parameter int blocksize = 8,
  parameter int PW        = 8,
  parameter int NP        = 6,
  parameter int N         = 12,
  parameter int ZBIAS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [blocksize*PW-1:0] cur_row,
  input  logic [blocksize*PW-1:0] ref_row,
  input  logic signed [N-1:0]     cand_dx,
  input  logic signed [N-1:0]     cand_dy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N-1:0]     best_dx,
  output logic signed [N-1:0]     best_dy,
  output logic [PW+NP-1:0]        best_sad,
  output logic [3:0]              best_idx
);

  localparam int RW  = PW + 3;
  localparam int SW  = PW + NP;
  localparam int RCW = (blocksize > 1) ? $clog2(blocksize) : 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [RCW-1:0]        row_cnt_q, row_cnt_d;
  logic [3:0]            cand_cnt_q, cand_cnt_d;
  logic [3:0]            cand_idx_q, cand_idx_d;
  logic signed [N-1:0]   cand_dx_q, cand_dx_d;
  logic signed [N-1:0]   cand_dy_q, cand_dy_d;
  logic [RW-1:0]         row_sad_q, row_sad_d;
  logic                  last_q, last_d;
  logic [SW-1:0]         acc_q, acc_d;
  logic [SW-1:0]         min_sad_q, min_sad_d;
  logic signed [N-1:0]   best_dx_q, best_dx_d;
  logic signed [N-1:0]   best_dy_q, best_dy_d;
  logic [3:0]            best_idx_q, best_idx_d;

  logic [RW-1:0]         row_sum_s;
  logic [PW-1:0]         cur_px_s, ref_px_s, diff_s;
  logic [SW-1:0]         total_s, cmp_s;
  logic                  hs_s;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign best_dx   = best_dx_q;
  assign best_dy   = best_dy_q;
  assign best_sad  = min_sad_q;
  assign best_idx  = best_idx_q;
  assign hs_s      = in_valid & in_ready;

  // Row SAD: sum of per-pixel absolute differences.
  always_comb begin
    row_sum_s = '0;
    cur_px_s  = '0;
    ref_px_s  = '0;
    diff_s    = '0;
    for (int i = 0; i < blocksize; i++) begin
      cur_px_s = cur_row[i*PW +: PW];
      ref_px_s = ref_row[i*PW +: PW];
      if (cur_px_s >= ref_px_s) begin
        diff_s = cur_px_s - ref_px_s;
      end else begin
        diff_s = ref_px_s - cur_px_s;
      end
      row_sum_s = row_sum_s + RW'(diff_s);
    end
  end

  // Candidate total and the value it competes with (optionally zero-biased).
  always_comb begin
    total_s = acc_q + SW'(row_sad_q);
    cmp_s   = total_s;
`ifdef MV_ZERO_BIAS_EN
    if ((cand_dx_q == '0) && (cand_dy_q == '0)) begin
      if (total_s > SW'(ZBIAS)) begin
        cmp_s = total_s - SW'(ZBIAS);
      end else begin
        cmp_s = '0;
      end
    end else begin
      cmp_s = total_s;
    end
`endif
  end

  // Next-state: counters, accumulation, minimum tracking and FSM.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    cand_cnt_d = cand_cnt_q;
    cand_idx_d = cand_idx_q;
    cand_dx_d  = cand_dx_q;
    cand_dy_d  = cand_dy_q;
    row_sad_d  = '0;
    last_d     = 1'b0;
    min_sad_d  = min_sad_q;
    best_dx_d  = best_dx_q;
    best_dy_d  = best_dy_q;
    best_idx_d = best_idx_q;
    // row_sad_q is zero on bubble cycles, so accumulating it then is harmless
    acc_d      = last_q ? '0 : total_s;

    if (last_q && (cmp_s < min_sad_q)) begin
      min_sad_d  = cmp_s;
      best_dx_d  = cand_dx_q;
      best_dy_d  = cand_dy_q;
      best_idx_d = cand_idx_q;
    end else begin
      min_sad_d  = min_sad_q;
    end

    if (hs_s) begin
      row_sad_d = row_sum_s;
      if (row_cnt_q == '0) begin
        cand_dx_d  = cand_dx;
        cand_dy_d  = cand_dy;
        cand_idx_d = cand_cnt_q;
      end else begin
        cand_idx_d = cand_idx_q;
      end
      if (row_cnt_q == RCW'(blocksize - 1)) begin
        row_cnt_d = '0;
        last_d    = 1'b1;
        if (cand_cnt_q == 4'd8) begin
          cand_cnt_d = 4'd0;
          state_d    = DRAIN;
        end else begin
          cand_cnt_d = cand_cnt_q + 4'd1;
        end
      end else begin
        row_cnt_d = row_cnt_q + RCW'(1);
      end
    end else begin
      row_sad_d = '0;
    end

    case (state_q)
      ACCUM: begin
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d   = ACCUM;
          min_sad_d = '1;
        end else begin
          state_d   = DONE;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      row_cnt_q  <= '0;
      cand_cnt_q <= 4'd0;
      cand_idx_q <= 4'd0;
      cand_dx_q  <= '0;
      cand_dy_q  <= '0;
      row_sad_q  <= '0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      min_sad_q  <= '1;
      best_dx_q  <= '0;
      best_dy_q  <= '0;
      best_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      cand_idx_q <= cand_idx_d;
      cand_dx_q  <= cand_dx_d;
      cand_dy_q  <= cand_dy_d;
      row_sad_q  <= row_sad_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      min_sad_q  <= min_sad_d;
      best_dx_q  <= best_dx_d;
      best_dy_q  <= best_dy_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule

// File: tb/tb_tss_sad_cmp.sv
// Directed scoreboard bench for tss_sad_cmp; honours MV_ZERO_BIAS_EN when defined.
module tb_tss_sad_cmp;

  localparam int ZB = 16;

  typedef struct {
    logic [3:0]  idx;
    logic [13:0] sad;
    logic [11:0] dx;
    logic [11:0] dy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] cur_row, ref_row;
  logic [11:0] cand_dx, cand_dy;
  logic [11:0] best_dx, best_dy;
  logic [13:0] best_sad;
  logic [3:0]  best_idx;

  logic [63:0] cur_m [9][8];
  logic [63:0] ref_m [9][8];
  logic [11:0] dx_m [9];
  logic [11:0] dy_m [9];
  int          ox [9] = '{0, -4, -4, -4, 0, 0, 4, 4, 4};
  int          oy [9] = '{0, -4, 0, 4, -4, 4, -4, 0, 4};
  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  tss_sad_cmp #(.blocksize(8), .PW(8), .NP(6), .N(12), .ZBIAS(ZB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cur_row(cur_row), .ref_row(ref_row), .cand_dx(cand_dx), .cand_dy(cand_dy),
    .out_valid(out_valid), .out_ready(out_ready), .best_dx(best_dx),
    .best_dy(best_dy), .best_sad(best_sad), .best_idx(best_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int c, input logic [7:0] cv, input logic [7:0] rv);
    for (int r = 0; r < 8; r++) begin
      cur_m[c][r] = {8{cv}};
      ref_m[c][r] = {8{rv}};
    end
  endtask

  // Reference: per-candidate SAD, strict minimum so the earliest tie wins.
  task automatic push_expected();
    exp_t e;
    int   best, s, a, b;
    best  = 32'h3FFF;
    e.idx = 4'd0; e.sad = 14'h3FFF; e.dx = 12'd0; e.dy = 12'd0;
    for (int c = 0; c < 9; c++) begin
      s = 0;
      for (int r = 0; r < 8; r++) begin
        for (int i = 0; i < 8; i++) begin
          a = int'(cur_m[c][r][i*8 +: 8]);
          b = int'(ref_m[c][r][i*8 +: 8]);
          s += (a >= b) ? a - b : b - a;
        end
      end
`ifdef MV_ZERO_BIAS_EN
      if (dx_m[c] == 12'd0 && dy_m[c] == 12'd0) s = (s > ZB) ? s - ZB : 0;
`endif
      if (s < best) begin
        best  = s;
        e.idx = 4'(c); e.sad = 14'(s); e.dx = dx_m[c]; e.dy = dy_m[c];
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input int nrows, input bit gaps);
    int c, r, n;
    for (int k = 0; k < nrows; k++) begin
      c = k / 8;
      r = k % 8;
      n = 0;
      while (gaps && n < 3 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        cur_row  = {$urandom, $urandom};
        @(negedge clk);
        n++;
      end
      in_valid = 1'b1;
      cur_row  = cur_m[c][r];
      ref_row  = ref_m[c][r];
      cand_dx  = (r == 0) ? dx_m[c] : 12'($urandom);
      cand_dy  = (r == 0) ? dy_m[c] : 12'($urandom);
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_fail++;
        $error("FAIL in_ready_timeout: observed=0 expected=1 at row %0d", k);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_step(input int hold);
    exp_t e;
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
      e.idx = 4'd0; e.sad = 14'd0; e.dx = 12'd0; e.dy = 12'd0;
    end else begin
      e = sb_q.pop_front();
    end
    chk("best_idx", 32'(best_idx), 32'(e.idx));
    chk("best_sad", 32'(best_sad), 32'(e.sad));
    chk("best_dx", 32'(best_dx), 32'(e.dx));
    chk("best_dy", 32'(best_dy), 32'(e.dy));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sad", 32'(best_sad), 32'(e.sad));
      chk("hold_idx", 32'(best_idx), 32'(e.idx));
      chk("hold_dx", 32'(best_dx), 32'(e.dx));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cur_row = '0; ref_row = '0; cand_dx = '0; cand_dy = '0;
    for (int c = 0; c < 9; c++) begin
      dx_m[c] = 12'(ox[c]);
      dy_m[c] = 12'(oy[c]);
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_best_sad", 32'(best_sad), 32'h3FFF);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    rst = 1'b0;

    // Uniform data: centre wins with SAD 0.
    for (int c = 0; c < 9; c++) fill(c, 8'h10, 8'h10);
    push_expected();
    drive(72, 1'b0);
    finish_step(0);

    // Single minimum at candidate 5, with output backpressure.
    for (int c = 0; c < 9; c++) fill(c, 8'h12, 8'h10);
    fill(5, 8'h11, 8'h10);
    push_expected();
    drive(72, 1'b0);
    finish_step(5);

    // Tie between 3 and 7 at SAD 10, others at maximum SAD.
    for (int c = 0; c < 9; c++) fill(c, 8'hFF, 8'h00);
    fill(3, 8'h00, 8'h00);
    fill(7, 8'h00, 8'h00);
    cur_m[3][0] = 64'h0A;
    cur_m[7][0] = 64'h0A;
    push_expected();
    drive(72, 1'b0);
    finish_step(0);

    // Reset mid-step at candidate 4 row 3.
    for (int c = 0; c < 9; c++) begin
      for (int r = 0; r < 8; r++) begin
        cur_m[c][r] = {$urandom, $urandom};
        ref_m[c][r] = {$urandom, $urandom};
      end
    end
    drive(35, 1'b0);
    in_valid = 1'b1;
    cur_row  = cur_m[4][3];
    ref_row  = ref_m[4][3];
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_best_sad", 32'(best_sad), 32'h3FFF);
    chk("midrst_best_idx", 32'(best_idx), 32'd0);
    chk("midrst_best_dx", 32'(best_dx), 32'd0);
    chk("midrst_best_dy", 32'(best_dy), 32'd0);
    push_expected();
    drive(72, 1'b0);
    finish_step(0);

    // Same data with random input bubbles.
    push_expected();
    drive(72, 1'b1);
    finish_step(2);

    // Zero bias: centre SAD 20, candidate 2 SAD 10.
    for (int c = 0; c < 9; c++) fill(c, 8'hFF, 8'h00);
    fill(0, 8'h00, 8'h00);
    fill(2, 8'h00, 8'h00);
    cur_m[0][0] = 64'h14;
    cur_m[2][0] = 64'h0A;
    push_expected();
    drive(72, 1'b0);
    finish_step(0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
